// File: rtl/adventure_pkg.sv
// ---------------------------------------------------------------------------
// adventure_pkg
// Shared types and helpers for the Adventure_Game move scheduler.
//   state_t      : scheduler FSM states
//   DIR_N..DIR_W : bit positions of each direction in a {n,s,e,w} vector
//   prio_onehot  : fixed-priority (N > S > E > W) request-to-one-hot encoder
// ---------------------------------------------------------------------------
package adventure_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      ISSUE    = 3'd2,
      SETTLE   = 3'd3,
      RELEASE  = 3'd4,
      OVER     = 3'd5
   } state_t;

   localparam int DIR_N = 3;
   localparam int DIR_S = 2;
   localparam int DIR_E = 1;
   localparam int DIR_W = 0;

   // Keep only the highest-priority requested direction.
   function automatic logic [3:0] prio_onehot(input logic [3:0] req);
      logic [3:0] oh;
      oh = 4'b0000;
      if (req[DIR_N]) begin
         oh[DIR_N] = 1'b1;
      end else if (req[DIR_S]) begin
         oh[DIR_S] = 1'b1;
      end else if (req[DIR_E]) begin
         oh[DIR_E] = 1'b1;
      end else if (req[DIR_W]) begin
         oh[DIR_W] = 1'b1;
      end else begin
         oh = 4'b0000;
      end
      return oh;
   endfunction

endpackage

// File: rtl/adventure_move_scheduler_btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync
// Two-flop synchronizer for a vector of asynchronous inputs.
//   clk   : system clock
//   reset : synchronous active-high reset, clears both stages
//   d     : raw asynchronous inputs
//   q     : synchronized outputs (two clock edges of latency)
// ---------------------------------------------------------------------------
module btn_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two-stage capture of the raw inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/adventure_move_scheduler.sv
// ---------------------------------------------------------------------------
// adventure_move_scheduler
// Synchronizes and debounces four direction buttons, picks one direction by
// fixed priority N > S > E > W, issues a single-cycle move pulse per press,
// waits for the room FSM to settle and locks out input after WIN/DIE.
//   clk, reset                : clock, synchronous active-high reset
//   btn_n/s/e/w               : raw asynchronous buttons
//   game_win, game_die        : status from the room FSM
//   N, S, E, W, move_valid    : one-hot move pulse and its qualifier
//   move_count                : saturating count of issued moves
//   busy, game_over           : FSM activity / absorbing OVER state
//   out_of_moves              : move budget exhausted
// Build option: define MOVE_LIMIT_EN to end the game after MAX_MOVES moves;
// without it out_of_moves is constant 0 and the count only saturates.
// ---------------------------------------------------------------------------
module adventure_move_scheduler
   import adventure_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SETTLE_CYCLES   = 2,
   parameter int CNT_W           = 8,
   parameter int MAX_MOVES       = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_n,
   input  logic             btn_s,
   input  logic             btn_e,
   input  logic             btn_w,
   input  logic             game_win,
   input  logic             game_die,
   output logic             N,
   output logic             S,
   output logic             E,
   output logic             W,
   output logic             move_valid,
   output logic [CNT_W-1:0] move_count,
   output logic             busy,
   output logic             game_over,
   output logic             out_of_moves
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ST_W-1:0]  ST_LAST = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       sync_s;
   logic             end_s;
   logic             limit_hit_s;
   logic             oom_set_s;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       cap_r;
   logic [DB_W-1:0]  deb_cnt_r;
   logic [ST_W-1:0]  set_cnt_r;
   logic [CNT_W-1:0] count_r;
   logic [3:0]       dir_r;
   logic             move_valid_r;
   logic             busy_r;
   logic             game_over_r;
   logic             oom_r;

   btn_sync #(.WIDTH(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({btn_n, btn_s, btn_e, btn_w}),
      .q     (sync_s)
   );

   assign end_s = game_win | game_die;

`ifdef MOVE_LIMIT_EN
   // count_r already includes the move just issued when SETTLE ends.
   assign limit_hit_s  = (count_r >= CNT_W'(MAX_MOVES));
   assign out_of_moves = oom_r;
`else
   logic unused_limit_s;
   assign limit_hit_s    = 1'b0;
   assign out_of_moves   = 1'b0;
   assign unused_limit_s = oom_r | (MAX_MOVES == 0);
`endif

   // Next-state selection; win/die overrides every state except OVER.
   always_comb begin
      state_nxt_s = state_r;
      oom_set_s   = 1'b0;
      if (end_s && (state_r != OVER)) begin
         state_nxt_s = OVER;
      end else begin
         case (state_r)
            IDLE: begin
               if (sync_s != 4'b0000) begin
                  state_nxt_s = DEBOUNCE;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            DEBOUNCE: begin
               if (sync_s != cap_r) begin
                  state_nxt_s = IDLE;
               end else if (deb_cnt_r == DB_LAST) begin
                  state_nxt_s = ISSUE;
               end else begin
                  state_nxt_s = DEBOUNCE;
               end
            end
            ISSUE: begin
               state_nxt_s = SETTLE;
            end
            SETTLE: begin
               if (set_cnt_r != ST_LAST) begin
                  state_nxt_s = SETTLE;
               end else if (limit_hit_s) begin
                  state_nxt_s = OVER;
                  oom_set_s   = 1'b1;
               end else begin
                  state_nxt_s = RELEASE;
               end
            end
            RELEASE: begin
               if (sync_s == 4'b0000) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = RELEASE;
               end
            end
            OVER: begin
               state_nxt_s = OVER;
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // State, counters and outputs; outputs are decoded from the next state so
   // they are registered yet line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cap_r        <= 4'b0000;
         deb_cnt_r    <= {DB_W{1'b0}};
         set_cnt_r    <= {ST_W{1'b0}};
         count_r      <= {CNT_W{1'b0}};
         dir_r        <= 4'b0000;
         move_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         game_over_r  <= 1'b0;
         oom_r        <= 1'b0;
      end else begin
         state_r <= state_nxt_s;

         // cap_r is frozen for the whole debounce window.
         if (state_r == IDLE) begin
            cap_r <= sync_s;
         end else begin
            cap_r <= cap_r;
         end

         if ((state_r == DEBOUNCE) && (state_nxt_s == DEBOUNCE)) begin
            deb_cnt_r <= deb_cnt_r + DB_W'(1);
         end else begin
            deb_cnt_r <= {DB_W{1'b0}};
         end

         if ((state_r == SETTLE) && (state_nxt_s == SETTLE)) begin
            set_cnt_r <= set_cnt_r + ST_W'(1);
         end else begin
            set_cnt_r <= {ST_W{1'b0}};
         end

         // The issued pulse always counts, even if win/die arrives with it.
         if ((state_r == ISSUE) && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
         end else begin
            count_r <= count_r;
         end

         if (state_nxt_s == ISSUE) begin
            dir_r        <= prio_onehot(cap_r);
            move_valid_r <= 1'b1;
         end else begin
            dir_r        <= 4'b0000;
            move_valid_r <= 1'b0;
         end

         busy_r      <= (state_nxt_s != IDLE) && (state_nxt_s != OVER);
         game_over_r <= (state_nxt_s == OVER);

         if (oom_set_s) begin
            oom_r <= 1'b1;
         end else begin
            oom_r <= oom_r;
         end
      end
   end

   assign N          = dir_r[DIR_N];
   assign S          = dir_r[DIR_S];
   assign E          = dir_r[DIR_E];
   assign W          = dir_r[DIR_W];
   assign move_valid = move_valid_r;
   assign move_count = count_r;
   assign busy       = busy_r;
   assign game_over  = game_over_r;

endmodule

// File: tb/tb_adventure_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adventure_move_scheduler
// Self-checking bench: reset checks, a table of single presses, hand-written
// multi-cycle sequences (reset during ISSUE, switch mid-debounce, die lockout,
// move limit or count saturation) and randomized presses against a
// press-level reference model.
// ---------------------------------------------------------------------------
module tb_adventure_move_scheduler;

   localparam int DEB  = 4;
   localparam int SET  = 2;
   localparam int CW   = 8;
   localparam int MAXM = 3;
`ifdef MOVE_LIMIT_EN
   localparam int LIMIT = MAXM;
`else
   localparam int LIMIT = 1 << 30;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          bn, bs, be, bw;
   logic          win, die;
   logic          N, S, E, W;
   logic          mv;
   logic [CW-1:0] cnt;
   logic          busy, go, oom;

   int total = 0;
   int bad   = 0;

   // model state
   int m_count = 0;
   bit m_over  = 1'b0;
   bit m_oom   = 1'b0;

   always #5 clk = ~clk;

   adventure_move_scheduler #(
      .DEBOUNCE_CYCLES (DEB),
      .SETTLE_CYCLES   (SET),
      .CNT_W           (CW),
      .MAX_MOVES       (MAXM)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (bn),
      .btn_s        (bs),
      .btn_e        (be),
      .btn_w        (bw),
      .game_win     (win),
      .game_die     (die),
      .N            (N),
      .S            (S),
      .E            (E),
      .W            (W),
      .move_valid   (mv),
      .move_count   (cnt),
      .busy         (busy),
      .game_over    (go),
      .out_of_moves (oom)
   );

   typedef struct {
      logic [3:0] btn;
      int         hold;
      logic [3:0] exp_dir;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input logic [3:0] b);
      {bn, bs, be, bw} = b;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      set_btn(4'b0000);
      win = 1'b0;
      die = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
      m_count = 0;
      m_over  = 1'b0;
      m_oom   = 1'b0;
   endtask

   // Highest-priority direction of a button set, as {N,S,E,W}.
   function automatic logic [3:0] ref_first(input logic [3:0] b);
      if (b[3]) return 4'b1000;
      if (b[2]) return 4'b0100;
      if (b[1]) return 4'b0010;
      if (b[0]) return 4'b0001;
      return 4'b0000;
   endfunction

   // One press of set b held for 'hold' cycles, then 'gap' idle cycles.
   // A firing press pulses exp_dir exactly DEB+3 cycles after it starts.
   task automatic press(input logic [3:0] b, input int hold, input int gap,
                        input logic [3:0] exp_dir, input string tag);
      logic [3:0] e;
      bit         fire;
      fire = (exp_dir != 4'b0000) && !m_over && (m_count < LIMIT);
      set_btn(b);
      for (int t = 1; t <= hold + gap; t++) begin
         tick();
         if (t == hold) set_btn(4'b0000);
         e = (fire && (t == DEB + 3)) ? exp_dir : 4'b0000;
         check({tag, " dir"}, {N, S, E, W}, e);
         check({tag, " valid"}, mv, (e != 4'b0000));
         if (fire && (t == DEB + 3)) check({tag, " busy@issue"}, busy, 1'b1);
      end
      if (fire) begin
         m_count = (m_count < 255) ? m_count + 1 : 255;
         if (m_count >= LIMIT) begin
            m_over = 1'b1;
            m_oom  = 1'b1;
         end
      end
      check({tag, " count"}, cnt, m_count);
      check({tag, " busy end"}, busy, 1'b0);
      check({tag, " over"}, go, m_over);
      check({tag, " oom"}, oom, m_oom);
   endtask

   initial begin
      logic [3:0] rb;
      int         rh;

      vecs[0] = '{4'b0010, 12, 4'b0010};  // E held long
      vecs[1] = '{4'b1001,  8, 4'b1000};  // N+W together -> N
      vecs[2] = '{4'b0100,  3, 4'b0000};  // glitch
      vecs[3] = '{4'b0100,  4, 4'b0000};  // one cycle too short
      vecs[4] = '{4'b0100,  5, 4'b0100};  // shortest press that issues
      vecs[5] = '{4'b1111,  6, 4'b1000};
      vecs[6] = '{4'b0110,  7, 4'b0100};
      vecs[7] = '{4'b0011,  9, 4'b0010};
      vecs[8] = '{4'b0001,  5, 4'b0001};

      // reset held 3 cycles with buttons idle
      do_reset(3);
      check("rst dir", {N, S, E, W}, 4'b0000);
      check("rst valid", mv, 1'b0);
      check("rst count", cnt, 0);
      check("rst busy", busy, 1'b0);
      check("rst over", go, 1'b0);
      check("rst oom", oom, 1'b0);
      tick();
      check("post rst busy", busy, 1'b0);

      // table of single presses, each from a fresh reset
      foreach (vecs[i]) begin
         do_reset(2);
         press(vecs[i].btn, vecs[i].hold, 12, vecs[i].exp_dir, $sformatf("vec%0d", i));
      end

      // reset arriving on the edge that would enter ISSUE
      do_reset(2);
      set_btn(4'b0010);
      repeat (DEB + 2) tick();
      check("pre-issue busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      check("rst@issue dir", {N, S, E, W}, 4'b0000);
      check("rst@issue valid", mv, 1'b0);
      check("rst@issue busy", busy, 1'b0);
      do_reset(1);
      repeat (3) tick();
      check("rst@issue count", cnt, 0);

      // E for 3 cycles then S: debounce restarts, single S pulse
      do_reset(2);
      set_btn(4'b0010);
      for (int t = 1; t <= 3; t++) begin
         tick();
         check("sw early dir", {N, S, E, W}, 4'b0000);
      end
      set_btn(4'b0100);
      for (int t = 1; t <= 24; t++) begin
         tick();
         if (t == 12) set_btn(4'b0000);
         check("sw dir", {N, S, E, W}, (t == DEB + 4) ? 4'b0100 : 4'b0000);
      end
      check("sw count", cnt, 1);
      check("sw busy", busy, 1'b0);

      // game_die during SETTLE locks out all further input
      do_reset(2);
      set_btn(4'b1000);
      repeat (DEB + 3) tick();
      check("die pulse", {N, S, E, W}, 4'b1000);
      tick();
      check("die settle busy", busy, 1'b1);
      check("die settle count", cnt, 1);
      die = 1'b1;
      tick();
      check("die over", go, 1'b1);
      check("die busy", busy, 1'b0);
      check("die oom", oom, 1'b0);
      die = 1'b0;
      set_btn(4'b0000);
      m_count = 1;
      m_over  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         rb = 4'($urandom_range(1, 15));
         press(rb, 8, 4, ref_first(rb), "locked");
      end
      do_reset(1);
      check("die rst over", go, 1'b0);
      check("die rst count", cnt, 0);
      check("die rst busy", busy, 1'b0);

`ifdef MOVE_LIMIT_EN
      // move budget of MAXM moves
      do_reset(2);
      for (int k = 0; k < MAXM; k++) begin
         press(4'b0010, 6, 10, 4'b0010, "limit");
      end
      check("limit over", go, 1'b1);
      check("limit oom", oom, 1'b1);
      check("limit count", cnt, MAXM);
      press(4'b1000, 8, 10, 4'b1000, "limit after");
`else
      // count saturation over 300 moves
      do_reset(2);
      for (int k = 0; k < 300; k++) begin
         press(4'b0001, 5, 9, 4'b0001, "sat");
      end
      check("sat count", cnt, 255);
      check("sat oom", oom, 1'b0);
      check("sat over", go, 1'b0);
`endif

      // randomized presses against the press-level model
      do_reset(2);
      for (int k = 0; k < 40; k++) begin
         rb = 4'($urandom_range(1, 15));
         rh = $urandom_range(1, 10);
         press(rb, rh, $urandom_range(9, 14),
               (rh >= DEB + 1) ? ref_first(rb) : 4'b0000, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
